// File: rtl/npc_pkg.sv
// Shared constants and the fetch-state encoding used by the NPC core front end.
package npc_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JALR   = 2'd2;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory and decode handshakes of the fetch unit; master is the fetch unit side.
interface instr_fetch_unit_if;
    import npc_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
    );

endinterface

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selection; also reused by the trace model.
module ifu_next_pc
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      npc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] next_pc
);

    // Select the next PC; sequential add wraps naturally at 2^XLEN.
    always_comb begin
        next_pc = pc + 64'd4;
        case (npc_sel)
            NPC_SEQ:    next_pc = pc + 64'd4;
            NPC_BRANCH: next_pc = branch_target;
            NPC_JALR:   next_pc = {jalr_target[XLEN-1:1], 1'b0};
            default:    next_pc = pc + 64'd4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and runs one imem read at a time (REQ -> WAIT -> HOLD).
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
    import npc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_unit_if.master     bus,
    input  logic [1:0]             npc_sel,
    input  logic [XLEN-1:0]        branch_target,
    input  logic [XLEN-1:0]        jalr_target
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]            perf_fetch_cnt,
    output logic [63:0]            perf_stall_cnt
`endif
);

    ifu_state_e      state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] next_pc_s;
    logic            instr_valid_r;
    logic [31:0]     instr_r;
    logic [XLEN-1:0] instr_pc_r;

    ifu_next_pc u_next_pc (
        .pc            (pc_r),
        .npc_sel       (npc_sel),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .next_pc       (next_pc_s)
    );

    // Request is decoded from the state register and masked by reset so it never leaks out during reset.
    assign bus.imem_req_valid = (state_r == IFU_REQ) && !rst;
    assign bus.imem_req_addr  = pc_r;
    assign bus.instr_valid    = instr_valid_r;
    assign bus.instr          = instr_r;
    assign bus.instr_pc       = instr_pc_r;

    // Fetch FSM with its registered outputs and PC update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IFU_REQ;
            pc_r          <= RESET_PC;
            instr_valid_r <= 1'b0;
            instr_r       <= NOP_INSTR;
            instr_pc_r    <= RESET_PC;
        end else begin
            case (state_r)
                IFU_REQ: begin
                    if (bus.imem_req_ready) begin
                        state_r <= IFU_WAIT;
                    end
                end
                IFU_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        instr_r       <= bus.imem_resp_data;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        state_r       <= IFU_HOLD;
                    end
                end
                IFU_HOLD: begin
                    if (bus.instr_ready) begin
                        pc_r          <= next_pc_s;
                        instr_valid_r <= 1'b0;
                        state_r       <= IFU_REQ;
                    end
                end
                default: begin
                    instr_valid_r <= 1'b0;
                    state_r       <= IFU_REQ;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt_r;
    logic [63:0] perf_stall_cnt_r;

    // Count consumed instructions and cycles spent waiting on memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_r <= 64'd0;
            perf_stall_cnt_r <= 64'd0;
        end else begin
            if (instr_valid_r && bus.instr_ready) begin
                perf_fetch_cnt_r <= perf_fetch_cnt_r + 64'd1;
            end
            if ((state_r == IFU_REQ) || (state_r == IFU_WAIT)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_r;
    assign perf_stall_cnt = perf_stall_cnt_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with hand-computed expected values.
module tb_instr_fetch_unit;
    import npc_pkg::*;

    logic            clk;
    logic            rst;
    logic [1:0]      npc_sel;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;
`ifdef IFU_PERF_CNT_EN
    logic [63:0]     perf_fetch_cnt;
    logic [63:0]     perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .npc_sel       (npc_sel),
        .branch_target (branch_target),
        .jalr_target   (jalr_target)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full fetch starting in REQ: accept, zero-wait response, consume with the given selector.
    task automatic do_fetch(input string tag, input logic [63:0] addr, input logic [31:0] data,
                            input logic [1:0] sel, input logic [63:0] bt, input logic [63:0] jt);
        check_val({tag, "_req_valid"}, {63'd0, bus.imem_req_valid}, 64'd1);
        check_val({tag, "_req_addr"}, bus.imem_req_addr, addr);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        check_val({tag, "_wait_no_req"}, {63'd0, bus.imem_req_valid}, 64'd0);
        step();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        check_val({tag, "_instr_valid"}, {63'd0, bus.instr_valid}, 64'd1);
        check_val({tag, "_instr"}, {32'd0, bus.instr}, {32'd0, data});
        check_val({tag, "_instr_pc"}, bus.instr_pc, addr);
        bus.instr_ready = 1'b1;
        npc_sel         = sel;
        branch_target   = bt;
        jalr_target     = jt;
        step();
        bus.instr_ready = 1'b0;
        npc_sel         = 2'd0;
        check_val({tag, "_consumed"}, {63'd0, bus.instr_valid}, 64'd0);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0000_0000;
        bus.instr_ready     = 1'b0;
        npc_sel             = 2'd0;
        branch_target       = 64'd0;
        jalr_target         = 64'd0;

        // Reset state
        step();
        step();
        check_val("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check_val("rst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("rst_instr", {32'd0, bus.instr}, 64'h0000_0000_0000_0013);
        check_val("rst_instr_pc", bus.instr_pc, 64'h0000_0000_8000_0000);
        rst = 1'b0;
        bus.imem_req_ready = 1'b0;
        #1;

        // Sequential, branch, jalr (bit 0 cleared, bit 1 kept)
        do_fetch("seq", 64'h0000_0000_8000_0000, 32'h0010_0093, 2'd0, 64'd0, 64'd0);
        do_fetch("br", 64'h0000_0000_8000_0004, 32'h0020_0113, 2'd1, 64'h0000_0000_8000_0100, 64'd0);
        do_fetch("jalr", 64'h0000_0000_8000_0100, 32'h0030_0193, 2'd2, 64'd0, 64'h0000_0000_8000_0203);

        // Address must stay stable while the request is not accepted
        step();
        check_val("req_stable_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        check_val("req_stable_addr", bus.imem_req_addr, 64'h0000_0000_8000_0202);

        // HOLD stall: three cycles without instr_ready
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0040_0213;
        step();
        bus.imem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = 32'h1111_1111;
            step();
            check_val("hold_valid", {63'd0, bus.instr_valid}, 64'd1);
            check_val("hold_instr", {32'd0, bus.instr}, 64'h0000_0000_0040_0213);
            check_val("hold_pc", bus.instr_pc, 64'h0000_0000_8000_0202);
            check_val("hold_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
        end
        bus.imem_resp_valid = 1'b0;
        bus.instr_ready = 1'b1;
        npc_sel = 2'd0;
        step();
        bus.instr_ready = 1'b0;

        // Wrap at the top of the address space
        do_fetch("to_top", 64'h0000_0000_8000_0206, 32'h0050_0293, 2'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        do_fetch("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313, 2'd0, 64'd0, 64'd0);
        check_val("wrap_addr", bus.imem_req_addr, 64'h0000_0000_0000_0000);

        // Reset while waiting for a response, then a stale response
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hBAD0_BAD0;
        #1;
        check_val("post_rst_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0000);
        step();
        bus.imem_resp_valid = 1'b0;
        check_val("stale_ignored", {63'd0, bus.instr_valid}, 64'd0);
        check_val("stale_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        do_fetch("refetch", 64'h0000_0000_8000_0000, 32'h0070_0393, 2'd0, 64'd0, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
